mdu_hilo: RTL and testbench

//  Iterative multiply/divide unit with HI/LO registers for the MIPS pipeline EX stage.

---
 rtl/mdu_hilo_if.sv | 38 +++
 rtl/mdu_hilo.sv | 171 +++++++++++++++++
 tb/tb_mdu_hilo.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mdu_hilo_if
// Description : EX-stage bundle between the pipeline and the multiply/divide
//               unit. The master (pipeline) presents ops and MFHI/MFLO
//               requests. The slave (mdu_hilo) returns HI/LO, status and the
//               stall request.
//   start, op, rs_val, rt_val, mf_req, flush : master -> slave
//   hi, lo, busy, done, stall_req            : slave  -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             mf_req;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall_req;

    modport master (
        output start, op, rs_val, rt_val, mf_req, flush,
        input  hi, lo, busy, done, stall_req
    );

    modport slave (
        input  start, op, rs_val, rt_val, mf_req, flush,
        output hi, lo, busy, done, stall_req
    );
endinterface
`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mdu_hilo
// Description : Iterative multiply/divide unit with HI/LO registers for the
//               EX stage. It handles MULT/MULTU (shift-add) and DIV/DIVU
//               (restoring division), one bit per cycle, plus MTHI/MTLO.
//               The HI/LO registers are read combinationally for MFHI/MFLO.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-low
//               bus   - mdu_hilo_if.slave (op request, HI/LO, busy, done,
//                       stall_req)
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mdu_hilo_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // mult: {partial, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]   r_b;        // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_res;  // operand signs differ
    logic               r_neg_rem;  // dividend was negative
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    // Operand preparation
    logic               w_accept;
    logic               w_signed;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;

    assign w_accept = bus.start & ~bus.flush & (r_state == ST_IDLE);
    assign w_signed = ~bus.op[0];   // op 0 (MULT) and 2 (DIV) are signed
    assign w_rs_neg = w_signed & bus.rs_val[WIDTH-1];
    assign w_rt_neg = w_signed & bus.rt_val[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? (-bus.rs_val) : bus.rs_val;
    assign w_rt_mag = w_rt_neg ? (-bus.rt_val) : bus.rt_val;

    // One shift-add multiply step
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // One restoring divide step. The remainder stays below the divisor, so
    // the shifted remainder always fits in WIDTH+1 bits.
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    // Sign fixup. A divide by zero leaves the dividend magnitude in the
    // remainder, so the dividend-sign fixup restores rs_val exactly.
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    assign w_prod_fix = r_neg_res ? (-r_acc) : r_acc;
    assign w_quo_fix  = r_div0 ? {WIDTH{1'b1}}
                      : (r_neg_res ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0]);
    assign w_rem_fix  = r_neg_rem ? (-r_acc[2*WIDTH-1:WIDTH])
                                  : r_acc[2*WIDTH-1:WIDTH];

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state. Once in FIX the result is committed; a flush is too late.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && !bus.op[2]) w_state_next = ST_RUN;
            ST_RUN: begin
                if (bus.flush)           w_state_next = ST_IDLE;
                else if (r_cnt == '0)    w_state_next = ST_FIX;
            end
            ST_FIX:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath and HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!bus.op[2]) begin
                            r_is_div  <= bus.op[1];
                            r_neg_res <= w_rs_neg ^ w_rt_neg;
                            r_neg_rem <= w_rs_neg;
                            r_div0    <= bus.op[1] & (bus.rt_val == '0);
                            r_b       <= bus.op[1] ? w_rt_mag : w_rs_mag;
                            r_acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? w_rs_mag : w_rt_mag)};
                            r_cnt     <= CNT_W'(WIDTH - 1);
                        end else if (bus.op == 3'd4) begin
                            r_hi <= bus.rs_val;
                        end else if (bus.op == 3'd5) begin
                            r_lo <= bus.rs_val;
                        end
                    end
                end
                ST_RUN: begin
                    if (!bus.flush) begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.stall_req = bus.busy & (bus.start | bus.mf_req);

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mdu_hilo
// Description : Testbench for mdu_hilo. Expected {hi,lo} results are queued
//               when a mult/div is issued, and a monitor pops them when done
//               pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_hilo;

    logic clk;
    logic reset;

    mdu_hilo_if #(.WIDTH(32)) bus ();

    mdu_hilo #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset && bus.done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got hi=0x%h lo=0x%h expected no done", bus.hi, bus.lo);
            end else begin
                check(name_q.pop_front(), {bus.hi, bus.lo}, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.flush = fl;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'd7; bus.flush = 1'b0;
    endtask

    task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, output int busy_cyc);
        bit got;
        exp_q.push_back(exp);
        name_q.push_back(name);
        drive(o, a, b, 1'b0);
        busy_cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin got = 1'b1; break; end
            if (bus.busy) busy_cyc++;
        end
        if (!got) check({name, "_timeout"}, 64'(got), 64'd1);
        @(negedge clk);
        check({name, "_done_once"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        logic [31:0] h0, l0;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = 3'd7; bus.rs_val = '0; bus.rt_val = '0;
        bus.mf_req = 1'b0; bus.flush = 1'b0;
        #3;
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // 1. MULT -2 * 3
        run_md("mult_neg", 3'd0, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, bc);
        check("mult_busy_cycles", 64'(bc), 64'd33);
        // 2. MULTU max * max
        run_md("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, bc);
        run_md("mult_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, bc);
        // 3. Division
        run_md("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, bc);
        run_md("divu_100_7", 3'd3, 32'd100, 32'd7, 64'h00000002_0000000E, bc);
        run_md("div_7_m2", 3'd2, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, bc);
        // 4. Boundaries
        run_md("divu_by0", 3'd3, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF, bc);
        run_md("div_m7_by0", 3'd2, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, bc);
        run_md("div_intmin_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, bc);

        // MTHI / MTLO, flush in idle, ignored op
        drive(3'd4, 32'hAAAA5555, 32'd0, 1'b0);
        bus.mf_req = 1'b1;
        @(negedge clk);
        check("mthi", {bus.hi, bus.lo}, 64'hAAAA5555_80000000);
        check("mf_idle_no_stall", 64'(bus.stall_req), 64'd0);
        bus.mf_req = 1'b0;
        drive(3'd5, 32'h11112222, 32'd0, 1'b1);
        @(negedge clk);
        check("mtlo_flushed", {bus.hi, bus.lo}, 64'hAAAA5555_80000000);
        drive(3'd0, 32'd3, 32'd4, 1'b1);
        @(negedge clk);
        check("mult_flushed_idle", 64'(bus.busy), 64'd0);
        drive(3'd6, 32'd9, 32'd9, 1'b0);
        @(negedge clk);
        check("op6_ignored", {bus.hi, bus.lo, 31'd0, bus.busy}, {64'hAAAA5555_80000000, 32'd0});

        // 5. Stall while busy, then flush mid-run
        h0 = bus.hi; l0 = bus.lo;
        drive(3'd0, 32'd3, 32'd4, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 3'd4; bus.rs_val = 32'd5; bus.mf_req = 1'b1;
        @(negedge clk);
        check("stall_busy", 64'(bus.stall_req), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("mthi_blocked", 64'(bus.hi), 64'(h0));
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'd7; bus.mf_req = 1'b0; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_hilo", {bus.hi, bus.lo}, {h0, l0});
        repeat (40) @(negedge clk);
        check("flush_no_result", {bus.hi, bus.lo}, {h0, l0});

        // 6. Asynchronous reset mid-divide
        drive(3'd2, 32'd1000, 32'd3, 1'b0);
        repeat (18) @(posedge clk);
        #2;
        check("div_in_flight", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        check("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("async_reset_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(3'd5, 32'd7, 32'd0, 1'b0);
        bus.mf_req = 1'b1;
        @(negedge clk);
        check("mtlo_mflo", 64'(bus.lo), 64'd7);
        check("mflo_no_stall", 64'(bus.stall_req), 64'd0);
        bus.mf_req = 1'b0;
        repeat (40) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
